// File: rtl/rf_pkg.sv
// Shared widths, limits and FSM state encoding for the rf_meas clock measurement block.
package rf_pkg;

  localparam int unsigned      CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REF,
    WAIT_SIG,
    MEAS_HIGH,
    MEAS_LOW,
    DONE
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rf_edge_sync.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// Edge pulses appear three refclk cycles after the asynchronous input changes.
module rf_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_s3, r_rise, r_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/rf_meas.sv
// Measures sig_in high/low time and its phase lag behind ref_in, in refclk cycles.
// Define RF_MEAS_TIMEOUT_EN to abort any state that dwells 1023 cycles (timeout=1).
module rf_meas
  import rf_pkg::*;
(
  input  logic             refclk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             ref_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             timeout
);

  logic             w_sig_rise, w_sig_fall, w_ref_rise, w_ref_fall_unused;
  logic             w_dwell_hit;
  logic [CNT_W-1:0] w_cnt_inc;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt, r_phase, r_high;
  logic [CNT_W-1:0] r_high_cnt, r_low_cnt, r_phase_cnt;
  logic             r_busy, r_valid, r_timeout;

  rf_edge_sync u_sig_sync (
    .i_clk  (refclk),
    .i_rst  (reset),
    .i_d    (sig_in),
    .o_rise (w_sig_rise),
    .o_fall (w_sig_fall)
  );

  rf_edge_sync u_ref_sync (
    .i_clk  (refclk),
    .i_rst  (reset),
    .i_d    (ref_in),
    .o_rise (w_ref_rise),
    .o_fall (w_ref_fall_unused)
  );

  // Working counter is cleared on every state entry, so it doubles as the dwell timer.
  assign w_cnt_inc = sat_inc(r_cnt);

`ifdef RF_MEAS_TIMEOUT_EN
  assign w_dwell_hit = (w_cnt_inc == CNT_MAX);
`else
  assign w_dwell_hit = 1'b0;
`endif

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_high      <= '0;
      r_high_cnt  <= '0;
      r_low_cnt   <= '0;
      r_phase_cnt <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= WAIT_REF;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        WAIT_REF: begin
          if (w_ref_rise && w_sig_rise) begin
            r_state <= MEAS_HIGH;
            r_phase <= '0;
            r_cnt   <= '0;
          end else if (w_ref_rise) begin
            r_state <= WAIT_SIG;
            r_cnt   <= '0;
          end else if (w_dwell_hit) begin
            r_state     <= DONE;
            r_valid     <= 1'b1;
            r_timeout   <= 1'b1;
            r_phase_cnt <= CNT_MAX;
            r_high_cnt  <= CNT_MAX;
            r_low_cnt   <= CNT_MAX;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        WAIT_SIG: begin
          if (w_sig_rise) begin
            r_state <= MEAS_HIGH;
            r_phase <= w_cnt_inc;
            r_cnt   <= '0;
          end else if (w_dwell_hit) begin
            r_state     <= DONE;
            r_valid     <= 1'b1;
            r_timeout   <= 1'b1;
            r_phase_cnt <= CNT_MAX;
            r_high_cnt  <= CNT_MAX;
            r_low_cnt   <= CNT_MAX;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        MEAS_HIGH: begin
          if (w_sig_fall) begin
            r_state <= MEAS_LOW;
            r_high  <= w_cnt_inc;
            r_cnt   <= '0;
          end else if (w_dwell_hit) begin
            r_state     <= DONE;
            r_valid     <= 1'b1;
            r_timeout   <= 1'b1;
            r_phase_cnt <= r_phase;
            r_high_cnt  <= CNT_MAX;
            r_low_cnt   <= CNT_MAX;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        MEAS_LOW: begin
          if (w_sig_rise || w_dwell_hit) begin
            r_state     <= DONE;
            r_valid     <= 1'b1;
            r_timeout   <= ~w_sig_rise;
            r_phase_cnt <= r_phase;
            r_high_cnt  <= r_high;
            r_low_cnt   <= w_sig_rise ? w_cnt_inc : CNT_MAX;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign high_cnt  = r_high_cnt;
  assign low_cnt   = r_low_cnt;
  assign phase_cnt = r_phase_cnt;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rf_meas.sv
// Self-checking bench for rf_meas: directed and random periodic waveforms checked against
// an edge-timing reference model computed from the recorded input history.
module tb_rf_meas;

  localparam int MAXC = 20000;
`ifdef RF_MEAS_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       reset, sig_in, ref_in, start;
  logic       busy, valid, timeout;
  logic [9:0] high_cnt, low_cnt, phase_cnt;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  bit sh [MAXC];
  bit rh [MAXC];

  always #5 refclk = ~refclk;

  rf_meas dut (
    .refclk    (refclk),
    .reset     (reset),
    .sig_in    (sig_in),
    .ref_in    (ref_in),
    .start     (start),
    .busy      (busy),
    .valid     (valid),
    .high_cnt  (high_cnt),
    .low_cnt   (low_cnt),
    .phase_cnt (phase_cnt),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    assert (got === 32'(exp)) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive the recorded value for the next edge, take the edge, sample 1 time unit later.
  task automatic tick();
    if (n + 1 >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected <%0d", n + 1, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    sig_in = sh[n+1];
    ref_in = rh[n+1];
    @(posedge refclk);
    n++;
    #1;
  endtask

  task automatic set_wave(input bit s_on, input int s_half, input int s_off,
                          input bit r_on, input int r_half, input int r_off);
    for (int t = n + 1; t < MAXC; t++) begin
      sh[t] = s_on && ((((t + s_off) / s_half) % 2) == 1);
      rh[t] = r_on && ((((t + r_off) / r_half) % 2) == 1);
    end
  endtask

  // An input change first sampled at edge k is acted on by the FSM at edge k+3.
  function automatic bit ev(input bit is_ref, input bit want_rise, input int e);
    bit v1, v0;
    if (e < 4 || e >= MAXC) return 1'b0;
    v1 = is_ref ? rh[e-3] : sh[e-3];
    v0 = is_ref ? rh[e-4] : sh[e-4];
    return (v1 == want_rise) && (v0 != want_rise);
  endfunction

  function automatic int find(input bit is_ref, input bit want_rise, input int lo, input int hi);
    for (int e = lo; e <= hi; e++) if (ev(is_ref, want_rise, e)) return e;
    return -1;
  endfunction

  function automatic int cap(input int x);
    if (TmoEn) return (x + 1023 < MAXC) ? x + 1023 : MAXC - 1;
    return MAXC - 1;
  endfunction

  function automatic int sat(input int d);
    return (d > 1023) ? 1023 : d;
  endfunction

  // Expected outcome of a start sampled at edge s: valid edge, counts, timeout flag.
  task automatic predict(input int s, output bit ok, output int ve, output int a,
                         output int ph, output int hi, output int lo, output bit tmo);
    int r, f, b;
    ok = 1'b1; tmo = 1'b0; ve = -1; a = -1;
    ph = 1023; hi = 1023; lo = 1023;
    r = find(1'b1, 1'b1, s + 1, cap(s));
    if (r < 0) begin ok = TmoEn; tmo = 1'b1; ve = s + 1023; return; end
    a = ev(1'b0, 1'b1, r) ? r : find(1'b0, 1'b1, r + 1, cap(r));
    if (a < 0) begin ok = TmoEn; tmo = 1'b1; ve = r + 1023; return; end
    ph = sat(a - r);
    f = find(1'b0, 1'b0, a + 1, cap(a));
    if (f < 0) begin ok = TmoEn; tmo = 1'b1; ve = a + 1023; return; end
    hi = sat(f - a);
    b = find(1'b0, 1'b1, f + 1, cap(f));
    if (b < 0) begin ok = TmoEn; tmo = 1'b1; ve = f + 1023; return; end
    lo = sat(b - f);
    ve = b;
  endtask

  task automatic measure(input string tag, input int budget, input bit poke);
    bit ok, tmo;
    int ve, a, ph, hi, lo, vseen;
    predict(n + 1, ok, ve, a, ph, hi, lo, tmo);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy_on"}, busy, 1);
    vseen = 0;
    if (ok) begin
      for (int k = 0; n < ve && k < 4000; k++) begin
        start = poke && (k == 2) && (n + 1 < ve);
        tick();
        start = 1'b0;
        if (valid && n < ve) vseen++;
      end
      chk({tag, ".valid"}, valid, 1);
      chk({tag, ".high"}, high_cnt, hi);
      chk({tag, ".low"}, low_cnt, lo);
      chk({tag, ".phase"}, phase_cnt, ph);
      chk({tag, ".timeout"}, timeout, tmo);
      chk({tag, ".busy_done"}, busy, 1);
      tick();
      chk({tag, ".valid_once"}, valid, 0);
      chk({tag, ".busy_off"}, busy, 0);
      chk({tag, ".high_held"}, high_cnt, hi);
      chk({tag, ".early_valid"}, vseen, 0);
    end else begin
      for (int k = 0; k < budget; k++) begin
        tick();
        if (valid) vseen++;
      end
      chk({tag, ".no_valid"}, vseen, 0);
      chk({tag, ".busy_stuck"}, busy, 1);
      chk({tag, ".timeout0"}, timeout, 0);
    end
  endtask

  initial begin
    bit ok, tmo;
    int ve, a, ph, hi, lo, vseen;

    reset = 1'b1; start = 1'b0; sig_in = 1'b0; ref_in = 1'b0;
    set_wave(1'b0, 1, 0, 1'b0, 1, 0);
    repeat (3) tick();
    chk("rst.busy", busy, 0);
    chk("rst.valid", valid, 0);
    chk("rst.high", high_cnt, 0);
    chk("rst.low", low_cnt, 0);
    chk("rst.phase", phase_cnt, 0);
    chk("rst.timeout", timeout, 0);
    reset = 1'b0;
    repeat (5) tick();

    // Identical sig/ref toggling every 5 cycles.
    set_wave(1'b1, 5, 0, 1'b1, 5, 0);
    repeat (10) tick();
    measure("same5", 0, 1'b0);

    // sig is ref delayed 3 cycles, period 16; second start pulsed while busy.
    set_wave(1'b1, 8, 13, 1'b1, 8, 16);
    repeat (10) tick();
    measure("dly3", 0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      set_wave(1'b1, $urandom_range(2, 40), $urandom_range(0, 79),
               1'b1, $urandom_range(2, 40), $urandom_range(0, 79));
      repeat ($urandom_range(1, 20)) tick();
      measure($sformatf("rnd%0d", i), 0, 1'($urandom_range(0, 1)));
    end

    set_wave(1'b1, 256, 0, 1'b1, 256, 5);
    repeat (3) tick();
    measure("slow256", 0, 1'b0);

    // sig stuck low: timeout build reports after 1023 cycles, otherwise waits forever.
    set_wave(1'b0, 1, 0, 1'b1, 6, 0);
    repeat (3) tick();
    measure("sig0", 1200, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Reset in the middle of MEAS_HIGH.
    set_wave(1'b1, 20, 0, 1'b1, 20, 0);
    repeat (5) tick();
    predict(n + 1, ok, ve, a, ph, hi, lo, tmo);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; n < a + 4 && k < 200; k++) tick();
    reset = 1'b1;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.valid", valid, 0);
    chk("midrst.high", high_cnt, 0);
    chk("midrst.low", low_cnt, 0);
    chk("midrst.phase", phase_cnt, 0);
    chk("midrst.timeout", timeout, 0);
    tick();
    chk("midrst.busy_next", busy, 0);
    reset = 1'b0;
    vseen = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (valid) vseen++;
    end
    chk("midrst.no_valid", vseen, 0);
    measure("after_rst", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
